// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared state encoding and default width for the GCD offload responder
package gcd_pkg;

  // default operand, result and step-count width
  localparam int GCD_W = 16;

  // responder sequencing: wait for a request, iterate, hold the result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gcd_step.sv
// rtl/gcd_step.sv - one subtraction step of the GCD iteration (pure datapath)
module gcd_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] next_a,
  output logic [W-1:0] next_b,
  output logic         eq,
  output logic         did_sub
);

  // subtract the smaller operand from the larger; equal operands mean the GCD is found
  always_comb begin
    next_a  = a;
    next_b  = b;
    eq      = (a == b);
    did_sub = (a != b);
    if (a > b) begin
      next_a = a - b;
    end else if (a < b) begin
      next_b = b - a;
    end
  end

endmodule

// File: rtl/gcd_responder.sv
// rtl/gcd_responder.sv - single-outstanding GCD responder with valid/ready request and response channels
module gcd_responder
  import gcd_pkg::*;
#(
  parameter int W = GCD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_gcd,
  output logic [W-1:0] resp_steps,
  output logic         busy
);

  state_t       state;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [W-1:0] steps_q;
  logic [W-1:0] result_q;
  logic         req_ready_q;
  logic         resp_valid_q;
  logic         busy_q;

  logic [W-1:0] step_a;
  logic [W-1:0] step_b;
  logic         step_eq;
  logic         step_sub;

  gcd_step #(
    .W(W)
  ) u_step (
    .a      (a_q),
    .b      (b_q),
    .next_a (step_a),
    .next_b (step_b),
    .eq     (step_eq),
    .did_sub(step_sub)
  );

  // sequencing, operand/step registers and the registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      steps_q      <= '0;
      result_q     <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            steps_q     <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if ((req_a == '0) || (req_b == '0)) begin
              // a zero operand makes the other one the GCD, no iteration needed
              result_q     <= req_a | req_b;
              resp_valid_q <= 1'b1;
              state        <= DONE;
            end else begin
              a_q   <= req_a;
              b_q   <= req_b;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (step_eq) begin
            result_q     <= a_q;
            resp_valid_q <= 1'b1;
            state        <= DONE;
          end else if (step_sub) begin
            a_q     <= step_a;
            b_q     <= step_b;
            steps_q <= steps_q + W'(1);
          end
        end
        DONE: begin
          // result and step count stay on the outputs after the handshake
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign busy       = busy_q;
  assign resp_gcd   = result_q;
  assign resp_steps = steps_q;

endmodule

// File: tb/tb_gcd_responder.sv
// tb/tb_gcd_responder.sv - randomized scoreboard bench for gcd_responder
module tb_gcd_responder;

  typedef struct {
    logic [15:0] g;
    logic [15:0] s;
    int          acc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [15:0] resp_gcd;
  logic [15:0] resp_steps;
  logic        busy;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          mon_en   = 1'b0;
  bit          rr_rand  = 1'b0;
  bit          rr_val   = 1'b0;
  bit          prev_valid = 1'b0;
  bit          post_hs  = 1'b0;
  int          hs_edge  = 0;
  logic [15:0] hold_g;
  logic [15:0] hold_s;

  gcd_responder #(.W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_gcd  (resp_gcd),
    .resp_steps(resp_steps),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // resp_ready changes well away from both clock edges
  always begin
    @(posedge clk);
    #2;
    resp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_val;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // reference: Euclid by division; subtractive step count is the sum of quotients minus one
  function automatic void ref_gcd(input int unsigned a, input int unsigned b,
                                  output int unsigned g, output int unsigned s);
    int unsigned x, y, t, q;
    if (a == 0 || b == 0) begin
      g = a | b;
      s = 0;
    end else begin
      x = a; y = b; q = 0;
      while (y != 0) begin
        q += x / y;
        t  = x % y;
        x  = y;
        y  = t;
      end
      g = x;
      s = q - 1;
    end
  endfunction

  // called at a negedge; returns the cycle count of the accepting edge
  task automatic do_req(input logic [15:0] a, input logic [15:0] b, input bit eager,
                        input logic [15:0] eg, input logic [15:0] es, output int acc);
    bit   was;
    exp_t e;
    acc = -1;
    for (int i = 0; i < 70000 && acc < 0; i++) begin
      if (eager || req_ready) begin
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
      end
      was = req_ready;
      @(posedge clk);
      #1;
      if (was) begin
        acc   = cyc;
        e.g   = eg;
        e.s   = es;
        e.acc = acc;
        e.lat = (a == 0 || b == 0) ? 0 : int'(es) + 1;
        sb.push_back(e);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    req_a     = 16'($urandom);
    req_b     = 16'($urandom);
    if (acc < 0) fail_now("request_accept_timeout");
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((sb.size() != 0 || !req_ready) && i < 70000) begin
      @(negedge clk);
      i++;
    end
    if (i >= 70000) fail_now("response_timeout");
  endtask

  // scoreboard monitor: latency, hold stability, result compare and post-handshake IDLE
  always @(negedge clk) begin
    if (!reset && mon_en) begin
      if (post_hs) begin
        chk("idle_after_handshake", {30'd0, resp_valid, req_ready}, 32'd1);
        post_hs = 1'b0;
      end
      chk("busy_vs_req_ready", busy, !req_ready);
      if (resp_valid) begin
        chk("req_ready_low_in_done", req_ready, 0);
        if (!prev_valid) begin
          if (sb.size() == 0) fail_now("spurious_resp_valid");
          else chk("resp_latency", cyc - sb[0].acc, sb[0].lat);
          hold_g = resp_gcd;
          hold_s = resp_steps;
        end else begin
          chk("held_gcd", resp_gcd, hold_g);
          chk("held_steps", resp_steps, hold_s);
        end
        if (resp_ready && sb.size() != 0) begin
          chk("resp_gcd", resp_gcd, sb[0].g);
          chk("resp_steps", resp_steps, sb[0].s);
          void'(sb.pop_front());
          post_hs = 1'b1;
          hs_edge = cyc + 1;
        end
      end
      prev_valid = resp_valid;
    end else begin
      prev_valid = 1'b0;
      post_hs    = 1'b0;
    end
  end

  initial begin
    logic [15:0] ta[7];
    logic [15:0] tb[7];
    logic [15:0] tg[7];
    logic [15:0] ts[7];
    int          acc;
    int unsigned g, s;
    logic [15:0] ra, rb;

    ta = '{16'd12, 16'd48, 16'd7, 16'd9, 16'd0, 16'd5, 16'd0};
    tb = '{16'd18, 16'd18, 16'd1, 16'd9, 16'd5, 16'd0, 16'd0};
    tg = '{16'd6,  16'd6,  16'd1, 16'd9, 16'd5, 16'd5, 16'd0};
    ts = '{16'd2,  16'd4,  16'd6, 16'd0, 16'd0, 16'd0, 16'd0};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_resp_gcd", resp_gcd, 0);
    chk("reset_resp_steps", resp_steps, 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    rr_val = 1'b1;
    @(negedge clk);

    // directed sweep including zero operands
    for (int i = 0; i < 7; i++) begin
      do_req(ta[i], tb[i], 1'b0, tg[i], ts[i], acc);
      drain();
    end

    // backpressure, then back-to-back requests held high while busy
    rr_val = 1'b0;
    @(negedge clk);
    do_req(16'd21, 16'd14, 1'b0, 16'd7, 16'd2, acc);
    for (int i = 0; i < 200 && !resp_valid; i++) @(negedge clk);
    if (!resp_valid) fail_now("backpressure_wait_timeout");
    repeat (10) @(negedge clk);
    chk("backpressure_req_ready", req_ready, 0);
    chk("backpressure_resp_valid", resp_valid, 1);
    rr_val = 1'b1;
    do_req(16'd30, 16'd12, 1'b1, 16'd6, 16'd3, acc);
    chk("b2b_gap_first", acc, hs_edge + 1);
    do_req(16'd8, 16'd12, 1'b1, 16'd4, 16'd2, acc);
    chk("b2b_gap_second", acc, hs_edge + 1);
    drain();

    // reset in the middle of a long computation discards it
    do_req(16'd65535, 16'd1, 1'b0, 16'd1, 16'd65534, acc);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midreset_req_ready", req_ready, 1);
    chk("midreset_resp_valid", resp_valid, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_resp_gcd", resp_gcd, 0);
    chk("midreset_resp_steps", resp_steps, 0);
    reset = 1'b0;
    @(negedge clk);
    do_req(16'd10, 16'd4, 1'b0, 16'd2, 16'd3, acc);
    drain();

    // worst-case step count
    do_req(16'd65535, 16'd1, 1'b0, 16'd1, 16'd65534, acc);
    drain();

    // randomized operands, randomized resp_ready, random eagerness
    rr_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 127));
      rb = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 127));
      ref_gcd(ra, rb, g, s);
      do_req(ra, rb, 1'($urandom_range(0, 1)), 16'(g), 16'(s), acc);
    end
    drain();
    rr_rand = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_responder.md
Name: gcd_responder

Overview:
- Responder end of the processor's GCD offload interface: the CISC processor acts as initiator and issues an operand pair; this block computes the GCD by iterative subtraction and returns the result plus a step count.
- Sits beside processor_CISC on the same clock and reset.
- Single outstanding request.
- Request and response channels each use a valid/ready handshake.

Parameters:
- W, 16, operand, result and step-count width in bits (W >= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- req_valid  input  1  initiator presents an operand pair.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_a  input  W  operand A.
- req_b  input  W  operand B.
- resp_valid  output  1  result available; high only in DONE.
- resp_ready  input  1  initiator accepts result.
- resp_gcd  output  W  GCD result.
- resp_steps  output  W  number of subtraction cycles used.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (any state): state=IDLE; regs a, b, steps, result cleared to 0.
  - Outputs after reset: req_ready=1, resp_valid=0, resp_gcd=0, resp_steps=0, busy=0.
  - An in-flight computation is discarded; no response is produced for it.
- States: IDLE, CALC, DONE (enum).
- IDLE, on req_valid && req_ready (request accepted):
  - If req_a==0 or req_b==0: result=req_a|req_b, steps=0, next state DONE. This covers gcd(0,0)=0.
  - Otherwise: a=req_a, b=req_b, steps=0, next state CALC.
  - req_valid without the handshake completing has no effect.
- CALC, one action per cycle:
  - a==b: result=a, next state DONE; steps unchanged.
  - a>b: a=a-b, steps=steps+1.
  - a<b: b=b-a, steps=steps+1.
  - Operands are nonzero in CALC, so subtraction never underflows.
  - steps cannot overflow: the maximum is 2^W-2, reached for (2^W-1, 1).
- Latency: if the request is accepted at edge T, resp_valid rises after edge T+n+1, where n = steps.
  - Zero-operand case: resp_valid rises after edge T.
- DONE:
  - resp_valid=1; resp_gcd and resp_steps are held stable while resp_ready=0.
  - On resp_valid && resp_ready: next state IDLE; resp_gcd and resp_steps keep their last value.
  - The next request cannot be accepted in the same cycle. Minimum spacing is one IDLE cycle between the response handshake and the next acceptance.
- req_a and req_b are sampled only at acceptance; later changes are ignored.
- resp_ready is ignored outside DONE.
- Registered outputs:
  - req_ready = (state==IDLE).
  - resp_valid = (state==DONE).
  - busy = (state!=IDLE).
- All arithmetic is unsigned, W bits.

Decomposition:
- Package gcd_pkg holds:
  - the state enum typedef (IDLE, CALC, DONE);
  - the default width constant GCD_W=16.
- Optional combinational sub-module gcd_step:
  - Inputs: a, b.
  - Outputs: next_a, next_b, eq, did_sub.
  - Keeps the FSM and the datapath separate.

Test Plan:
- Basic: req (12,18), resp_ready=1 -> resp_gcd=6, resp_steps=2, resp_valid rises 3 cycles after acceptance.
- Sweep: (48,18) -> 6/4. (7,1) -> 1/6. (9,9) -> 9/0, resp_valid one cycle after acceptance.
- Zeros: (0,5) -> 5/0. (5,0) -> 5/0. (0,0) -> 0/0. resp_valid on the cycle after acceptance.
- Backpressure: hold resp_ready=0 for 10 cycles in DONE -> resp_valid, resp_gcd, resp_steps stable and req_ready=0. Then pulse resp_ready -> IDLE next cycle; issue back-to-back requests and check one IDLE gap.
- Reset mid-op: accept (65535,1), assert reset at CALC cycle 100 -> next cycle IDLE, req_ready=1, resp_valid=0, outputs 0. A new request (10,4) -> 2/3.
- Worst case: (65535,1) -> resp_gcd=1, resp_steps=65534, no spurious resp_valid before completion.
